// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory port bundle for the load/store unit.
// slave = unit side; master = core + memory side.
interface mem_access_unit_if #(
    parameter int MEM_ADDR_WIDTH = 7
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_we;
    logic [1:0]                req_size;
    logic                      req_unsigned;
    logic [31:0]               req_addr;
    logic [31:0]               req_wdata;
    logic                      resp_valid;
    logic [31:0]               resp_rdata;
    logic                      resp_err;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]               mem_wdata;
    logic                      mem_we;
    logic [31:0]               mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit: maps byte/halfword/word accesses onto a word-wide memory,
// using read-modify-write for sub-word stores and lane extraction for loads.
module mem_access_unit #(
    parameter int MEM_ADDR_WIDTH = 7
) (
    input  logic               clk,
    input  logic               rst,
    mem_access_unit_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MERGE,
        WRITE,
        ERR
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    state_t                    state;
    logic [1:0]                size_q;
    logic                      unsigned_q;
    logic [1:0]                off_q;
    logic [31:0]               wdata_q;

    logic                      ready_q;
    logic                      valid_q;
    logic                      err_q;
    logic                      we_q;
    logic [31:0]               rdata_q;
    logic [MEM_ADDR_WIDTH-1:0] addr_q;
    logic [31:0]               mem_wdata_q;

    logic                      accept;
    logic                      req_bad;
    logic [7:0]                lane_b;
    logic [15:0]               lane_h;
    logic [31:0]               load_data;
    logic [31:0]               merge_data;

    assign accept = bus.req_valid && ready_q;

    always_comb begin
        req_bad = 1'b0;
        case (bus.req_size)
            SIZE_HALF: req_bad = bus.req_addr[0];
            SIZE_WORD: req_bad = (bus.req_addr[1:0] != 2'b00);
            SIZE_BYTE: req_bad = 1'b0;
            default:   req_bad = 1'b1;
        endcase
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        lane_b = bus.mem_rdata[7:0];
        case (off_q)
            2'd1:    lane_b = bus.mem_rdata[15:8];
            2'd2:    lane_b = bus.mem_rdata[23:16];
            2'd3:    lane_b = bus.mem_rdata[31:24];
            default: lane_b = bus.mem_rdata[7:0];
        endcase
        lane_h = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

        load_data = bus.mem_rdata;
        case (size_q)
            SIZE_BYTE: load_data = {{24{lane_b[7] & ~unsigned_q}}, lane_b};
            SIZE_HALF: load_data = {{16{lane_h[15] & ~unsigned_q}}, lane_h};
            default:   load_data = bus.mem_rdata;
        endcase
    end

    always_comb begin
        merge_data = bus.mem_rdata;
        if (size_q == SIZE_BYTE) begin
            case (off_q)
                2'd0:    merge_data[7:0]   = wdata_q[7:0];
                2'd1:    merge_data[15:8]  = wdata_q[7:0];
                2'd2:    merge_data[23:16] = wdata_q[7:0];
                default: merge_data[31:24] = wdata_q[7:0];
            endcase
        end else if (off_q[1]) begin
            merge_data[31:16] = wdata_q[15:0];
        end else begin
            merge_data[15:0] = wdata_q[15:0];
        end
    end

    // Completion flags are set on the edge that enters the completing state,
    // so they are registered yet line up with that state's cycle.
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ready_q     <= 1'b1;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            we_q        <= 1'b0;
            rdata_q     <= '0;
            addr_q      <= '0;
            mem_wdata_q <= '0;
            size_q      <= '0;
            unsigned_q  <= 1'b0;
            off_q       <= '0;
            wdata_q     <= '0;
        end else begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        ready_q    <= 1'b0;
                        size_q     <= bus.req_size;
                        unsigned_q <= bus.req_unsigned;
                        off_q      <= bus.req_addr[1:0];
                        wdata_q    <= bus.req_wdata;
                        if (req_bad) begin
                            state   <= ERR;
                            valid_q <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end else begin
                            addr_q <= bus.req_addr[MEM_ADDR_WIDTH+1:2];
                            if (!bus.req_we) begin
                                state   <= LOAD;
                                valid_q <= 1'b1;
                                err_q   <= 1'b0;
                            end else if (bus.req_size == SIZE_WORD) begin
                                state       <= WRITE;
                                we_q        <= 1'b1;
                                valid_q     <= 1'b1;
                                err_q       <= 1'b0;
                                rdata_q     <= '0;
                                mem_wdata_q <= bus.req_wdata;
                            end else begin
                                state <= MERGE;
                            end
                        end
                    end
                end
                LOAD: begin
                    rdata_q <= load_data;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                MERGE: begin
                    mem_wdata_q <= merge_data;
                    we_q        <= 1'b1;
                    valid_q     <= 1'b1;
                    err_q       <= 1'b0;
                    rdata_q     <= '0;
                    state       <= WRITE;
                end
                WRITE, ERR: begin
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // The load result is live during LOAD and held in rdata_q afterwards.
    assign bus.resp_rdata = (state == LOAD) ? load_data : rdata_q;
    assign bus.req_ready  = ready_q;
    assign bus.resp_err   = err_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    // A reset landing on the WRITE cycle must not let that write or its response escape.
    assign bus.mem_we     = we_q & ~rst;
    assign bus.resp_valid = valid_q & ~rst;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: table-driven requests against a
// behavioural word memory, with a response scoreboard and hand-written corner sequences.
module tb_mem_access_unit;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_we;
        logic [6:0]  exp_maddr;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic preload = 1'b1;
    logic [31:0] mem [128];

    int n_cmp = 0;
    int n_fail = 0;
    resp_t sb[$];
    vec_t vecs[$];

    mem_access_unit_if #(.MEM_ADDR_WIDTH(7)) bus ();

    mem_access_unit #(.MEM_ADDR_WIDTH(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 128; i++) mem[i] <= 32'h0;
            mem[0] <= 32'hA5A5_5A5A;
            mem[4] <= 32'h8081_F2F3;
            mem[8] <= 32'h1122_3344;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    assign bus.mem_rdata = mem[bus.mem_addr];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        resp_t e;
        if (bus.resp_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL sb_unexpected: response with nothing outstanding, rdata %h err %b",
                         bus.resp_rdata, bus.resp_err);
            end else begin
                e = sb.pop_front();
                check("sb_rdata", bus.resp_rdata, e.rdata);
                check("sb_err", 32'(bus.resp_err), 32'(e.err));
            end
        end
    end

    task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
    endtask

    task automatic do_req(input vec_t v, input string tag);
        int wait_n;
        int got_lat;
        int we_n;
        int we_lat;
        logic [6:0] we_addr;
        wait_n = 0; got_lat = 0; we_n = 0; we_lat = 0; we_addr = '0;
        @(negedge clk);
        while (!bus.req_ready && wait_n < 16) begin
            @(negedge clk);
            wait_n++;
        end
        check({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
        drive(v.we, v.size, v.uns, v.addr, v.wdata);
        sb.push_back('{v.exp_rdata, v.exp_err});
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus.mem_we) begin
                we_n++;
                we_lat = c;
                we_addr = bus.mem_addr;
            end
            if (bus.resp_valid) begin
                got_lat = c;
                break;
            end
        end
        @(negedge clk);
        if (bus.mem_we) we_n++;
        check({tag, "_lat"}, 32'(got_lat), 32'(v.exp_lat));
        check({tag, "_pulse"}, 32'(bus.resp_valid), 32'd0);
        check({tag, "_hold_err"}, 32'(bus.resp_err), 32'(v.exp_err));
        check({tag, "_hold_rdata"}, bus.resp_rdata, v.exp_rdata);
        check({tag, "_we_count"}, 32'(we_n), 32'(v.exp_we));
        if (v.exp_we != 0) begin
            check({tag, "_we_lat"}, 32'(we_lat), 32'(v.exp_lat));
            check({tag, "_we_addr"}, 32'(we_addr), 32'(v.exp_maddr));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int we_seen;
        vec_t rv;

        //          we    size   uns   addr          wdata          exp_rdata      err  lat we  maddr
        vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h0000_0010, 32'h0,         32'hFFFF_FFF3, 1'b0, 1, 0, 7'd0});
        vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h0000_0011, 32'h0,         32'h0000_00F2, 1'b0, 1, 0, 7'd0});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0,         32'hFFFF_8081, 1'b0, 1, 0, 7'd0});
        vecs.push_back('{1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0,         32'h0000_8081, 1'b0, 1, 0, 7'd0});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         32'h8081_F2F3, 1'b0, 1, 0, 7'd0});
        vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0,         32'hFFFF_FF80, 1'b0, 1, 0, 7'd0});
        vecs.push_back('{1'b0, 2'b01, 1'b1, 32'h0000_0010, 32'h0,         32'h0000_F2F3, 1'b0, 1, 0, 7'd0});
        vecs.push_back('{1'b1, 2'b00, 1'b0, 32'h0000_0021, 32'h1234_56AB, 32'h0,         1'b0, 2, 1, 7'd8});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0,         32'h1122_AB44, 1'b0, 1, 0, 7'd0});
        vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'hCAFE_BEEF, 32'h0,         1'b0, 2, 1, 7'd8});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0,         32'hBEEF_AB44, 1'b0, 1, 0, 7'd0});
        vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h0000_0004, 32'hDEAD_BEEF, 32'h0,         1'b0, 1, 1, 7'd1});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'h0,         32'hDEAD_BEEF, 1'b0, 1, 0, 7'd0});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0,         32'h0,         1'b1, 1, 0, 7'd0});
        vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h0000_0003, 32'h0000_5555, 32'h0,         1'b1, 1, 0, 7'd0});
        vecs.push_back('{1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0,         32'h0,         1'b1, 1, 0, 7'd0});
        vecs.push_back('{1'b1, 2'b11, 1'b0, 32'h0000_0020, 32'hFFFF_FFFF, 32'h0,         1'b1, 1, 0, 7'd0});
        vecs.push_back('{1'b1, 2'b00, 1'b0, 32'h0000_0023, 32'h0000_0077, 32'h0,         1'b0, 2, 1, 7'd8});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0,         32'h77EF_AB44, 1'b0, 1, 0, 7'd0});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h0000_0022, 32'h0,         32'h0000_77EF, 1'b0, 1, 0, 7'd0});
        vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h0000_0223, 32'h0,         32'h0000_0077, 1'b0, 1, 0, 7'd0});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0,         32'hA5A5_5A5A, 1'b0, 1, 0, 7'd0});
        vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h0000_0204, 32'h0102_0304, 32'h0,         1'b0, 1, 1, 7'd1});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'h0,         32'h0102_0304, 1'b0, 1, 0, 7'd0});

        // Reset with a request pending: it must be ignored.
        drive(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        preload = 1'b0;
        bus.req_valid = 1'b0;
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_err", 32'(bus.resp_err), 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            do_req(vecs[i], $sformatf("vec%0d", i));
        end
        check("err_word0_intact", mem[0], 32'hA5A5_5A5A);
        check("word4_intact", mem[4], 32'h8081_F2F3);

        // Back-to-back with req_valid held high; 0x202 aliases word 0.
        @(negedge clk);
        drive(1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'h0);
        sb.push_back('{32'h0102_0304, 1'b0});
        @(negedge clk);
        check("b2b_busy_ready", 32'(bus.req_ready), 32'd0);
        check("b2b_first_resp", 32'(bus.resp_valid), 32'd1);
        drive(1'b0, 2'b01, 1'b1, 32'h0000_0202, 32'h0);
        sb.push_back('{32'h0000_A5A5, 1'b0});
        @(negedge clk);
        check("b2b_idle_ready", 32'(bus.req_ready), 32'd1);
        check("b2b_gap_valid", 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("b2b_second_resp", 32'(bus.resp_valid), 32'd1);
        check("b2b_second_busy", 32'(bus.req_ready), 32'd0);
        check("b2b_alias_addr", 32'(bus.mem_addr), 32'd0);
        repeat (2) @(negedge clk);

        // Reset during MERGE of sb 0x21 aborts the store.
        drive(1'b1, 2'b00, 1'b0, 32'h0000_0021, 32'h0000_0099);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        check("merge_no_we", 32'(bus.mem_we), 32'd0);
        check("merge_no_resp", 32'(bus.resp_valid), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_req_ready", 32'(bus.req_ready), 32'd1);
        check("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("abort_resp_err", 32'(bus.resp_err), 32'd0);
        check("abort_resp_rdata", bus.resp_rdata, 32'd0);
        check("abort_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("abort_mem_wdata", bus.mem_wdata, 32'd0);
        we_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.mem_we) we_seen++;
        end
        check("abort_we_count", 32'(we_seen), 32'd0);
        check("abort_word_intact", mem[8], 32'h77EF_AB44);
        rv = '{1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0, 32'h77EF_AB44, 1'b0, 1, 0, 7'd0};
        do_req(rv, "post_abort_lw");

        repeat (2) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store unit between the MIPS core's MEM stage and the word-wide data memory. It accepts one load or store request at a time and translates byte/halfword/word accesses into word accesses on the memory's single-write-enable port. Sub-word stores use a read-modify-write sequence. Sub-word loads are lane-extracted and sign- or zero-extended.

## Interface

Parameters:
- MEM_ADDR_WIDTH, 7: word-address width of the data memory (128 words).

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle; a request is accepted when req_valid && req_ready at a posedge.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- req_unsigned  in  1  load zero-extends when 1 (lbu/lhu); ignored for stores.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; byte/halfword taken from the low bits.
- resp_valid  out  1  one-cycle pulse: request complete.
- resp_rdata  out  32  load result; valid with resp_valid; 0 for stores and errors.
- resp_err  out  1  misaligned or reserved-size request; valid with resp_valid.
- mem_addr  out  MEM_ADDR_WIDTH  word address to memory.
- mem_wdata  out  32  word write data to memory.
- mem_we  out  1  memory write enable.
- mem_rdata  in  32  combinational read data from memory at mem_addr.

## Operation

- On accept, register we, size, unsigned, byte offset (req_addr[1:0]) and wdata. mem_addr = req_addr[MEM_ADDR_WIDTH+1:2] is registered. Upper address bits are ignored, so accesses wrap modulo memory size.
- Lanes are little-endian: byte k = bits [8k+7:8k]. Halfword h = bits [16h+15:16h], h = addr[1].
- Error check at accept: size 11, halfword with addr[0]=1, or word with addr[1:0]≠00. Any of these causes an error completion. No memory access is made: mem_we stays 0 and memory is untouched.
- FSM states: IDLE, LOAD, MERGE, WRITE, ERR.
  - IDLE: req_ready=1. On accept, go to ERR if the error check fires. Otherwise go to LOAD for loads, WRITE for word stores, MERGE for byte/halfword stores.
  - LOAD: extract lane from mem_rdata, extend, register into resp_rdata. resp_valid=1. Next IDLE.
  - MERGE: register mem_rdata with the addressed lane(s) replaced by req_wdata low bits into mem_wdata. Next WRITE.
  - WRITE: mem_we=1 (word store: mem_wdata = registered req_wdata). resp_valid=1, resp_rdata=0. Next IDLE.
  - ERR: resp_valid=1, resp_err=1, resp_rdata=0. Next IDLE.
- req_ready=0 in every state except IDLE. req_valid while busy is ignored, not queued.
- mem_we is asserted only in WRITE, for exactly one cycle per store.

## Timing

- Accept at edge N:
  - load or error completes with resp_valid high during cycle N+1;
  - word store: WRITE in cycle N+1, memory updated at edge N+2, resp_valid in cycle N+1;
  - sub-word store: MERGE in cycle N+1, WRITE in cycle N+2, resp_valid in cycle N+2.
- req_ready returns high in the cycle after resp_valid. Maximum throughput is one load per 2 cycles and one sub-word store per 3 cycles.
- resp_rdata and resp_err hold their values until the next completion. resp_valid is a single-cycle pulse.
- Reset: state IDLE, req_ready=1 in the cycle after reset, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Reset asserted mid-operation (including MERGE or WRITE) aborts the request. No write reaches memory after the reset edge, and no response is produced.
- req_valid during reset is ignored.

## Test plan

- Word at 0x10 = 0x8081_F2F3:
  - lb 0x10 -> resp_rdata 0xFFFF_FFF3;
  - lbu 0x11 -> 0x0000_00F2;
  - lh 0x12 -> 0xFFFF_8081;
  - lhu 0x12 -> 0x0000_8081;
  - resp_valid exactly one cycle after each accept.
- Word at 0x20 = 0x1122_3344:
  - sb 0x21 data 0xAB -> word becomes 0x1122_AB44;
  - sh 0x22 data 0xBEEF -> 0xBEEF_AB44;
  - mem_we high exactly once, 2 cycles after accept.
- sw 0x04 data 0xDEAD_BEEF -> mem_we 1 cycle after accept, mem_addr=1; a following lw 0x04 returns 0xDEAD_BEEF.
- Misaligned cases -> resp_err=1, resp_rdata=0, mem_we never asserted, target words unchanged:
  - lw 0x06;
  - sh 0x03;
  - req_size=11.
- Back-to-back req_valid held high: req_ready low while busy, second request accepted the cycle after the first response, addr 0x200 aliases word 0.
- rst asserted during MERGE of sb 0x21 -> no mem_we, word unchanged, all outputs at reset values, req_ready=1 next cycle.
